// File: rtl/nco_seq_pkg.sv
// Shared opcode/state types and default widths for the NCO command sequencer.
package nco_seq_pkg;

    localparam int N            = 22;
    localparam int Z_CORR_WIDTH = 12;
    localparam int CNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        OP_SET_FTW = 2'b00,
        OP_VZ      = 2'b01,
        OP_RUN     = 2'b10,
        OP_WAIT    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FTW,
        ST_VZ_LOAD,
        ST_VZ_APPLY,
        ST_VZ_CLEAR,
        ST_RUN,
        ST_WAIT
    } state_e;

endpackage

// File: rtl/nco_sequencer.sv
// Expands SET_FTW / VZ / RUN / WAIT commands into cycle-exact NCO control strobes.
// Outputs are registered from the next state, so a command accepted at edge k drives cycle k..k+1.
module nco_sequencer #(
    parameter int N            = nco_seq_pkg::N,
    parameter int Z_CORR_WIDTH = nco_seq_pkg::Z_CORR_WIDTH,
    parameter int CNT_WIDTH    = nco_seq_pkg::CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [N-1:0]            cmd_data,
    input  logic                    abort,
    output logic                    ftw_wr_en,
    output logic [N-1:0]            ftw_out,
    output logic                    z_corr_wr_en,
    output logic [Z_CORR_WIDTH-1:0] z_corr_out,
    output logic                    phase_wr_en,
    output logic                    z_corr_mode,
    output logic                    cmd_done,
    output logic                    busy
);

    import nco_seq_pkg::*;

    state_e               state_q;
    state_e               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 last_cycle;
    logic                 accept;
    logic                 vz_aborted;

    logic                    ftw_wr_en_d;
    logic [N-1:0]            ftw_out_d;
    logic                    z_corr_wr_en_d;
    logic [Z_CORR_WIDTH-1:0] z_corr_out_d;
    logic                    phase_wr_en_d;
    logic                    z_corr_mode_d;
    logic                    cmd_done_d;

    // A zero count is also a last cycle, which gives RUN 0 / WAIT 0 their single cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        last_cycle = 1'b0;
        unique case (state_q)
            ST_FTW, ST_VZ_CLEAR: last_cycle = 1'b1;
            ST_RUN, ST_WAIT:     last_cycle = (cnt_q <= CNT_WIDTH'(1));
            default:             last_cycle = 1'b0;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign cmd_ready = !abort && (!busy || last_cycle);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        vz_aborted = 1'b0;

        unique case (state_q)
            ST_VZ_LOAD: begin
                state_d    = abort ? ST_VZ_CLEAR : ST_VZ_APPLY;
                vz_aborted = abort;
            end
            ST_VZ_APPLY: begin
                // The clear cycle is never skipped, so z_corr cannot stay loaded in the NCO.
                state_d    = ST_VZ_CLEAR;
                vz_aborted = abort;
            end
            ST_RUN, ST_WAIT: begin
                if (!abort && !last_cycle) begin
                    state_d = state_q;
                    cnt_d   = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept only happens in IDLE or a last cycle, so it overrides the fall-back to IDLE.
        if (accept) begin
            unique case (op_e'(cmd_op))
                OP_SET_FTW: state_d = ST_FTW;
                OP_VZ:      state_d = ST_VZ_LOAD;
                OP_RUN: begin
                    state_d = ST_RUN;
                    cnt_d   = cmd_data[CNT_WIDTH-1:0];
                end
                OP_WAIT: begin
                    state_d = ST_WAIT;
                    cnt_d   = cmd_data[CNT_WIDTH-1:0];
                end
            endcase
        end
    end

    always_comb begin
        ftw_out_d      = ftw_out;
        z_corr_out_d   = z_corr_out;
        ftw_wr_en_d    = (state_d == ST_FTW);
        z_corr_wr_en_d = (state_d == ST_VZ_LOAD) || (state_d == ST_VZ_CLEAR);
        z_corr_mode_d  = (state_d == ST_VZ_APPLY);
        phase_wr_en_d  = (state_d == ST_VZ_APPLY) ||
                         ((state_d == ST_RUN) && (cnt_d != '0));
        cmd_done_d     = 1'b0;

        if (accept && (op_e'(cmd_op) == OP_SET_FTW)) begin
            ftw_out_d = cmd_data;
        end
        if (accept && (op_e'(cmd_op) == OP_VZ)) begin
            z_corr_out_d = cmd_data[Z_CORR_WIDTH-1:0];
        end
        if (state_d == ST_VZ_CLEAR) begin
            z_corr_out_d = '0;
        end

        unique case (state_d)
            ST_FTW:          cmd_done_d = 1'b1;
            ST_VZ_CLEAR:     cmd_done_d = !vz_aborted;
            ST_RUN, ST_WAIT: cmd_done_d = (cnt_d <= CNT_WIDTH'(1));
            default:         cmd_done_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_wr_en    <= 1'b0;
            ftw_out      <= '0;
            z_corr_wr_en <= 1'b0;
            z_corr_out   <= '0;
            phase_wr_en  <= 1'b0;
            z_corr_mode  <= 1'b0;
            cmd_done     <= 1'b0;
        end else begin
            ftw_wr_en    <= ftw_wr_en_d;
            ftw_out      <= ftw_out_d;
            z_corr_wr_en <= z_corr_wr_en_d;
            z_corr_out   <= z_corr_out_d;
            phase_wr_en  <= phase_wr_en_d;
            z_corr_mode  <= z_corr_mode_d;
            cmd_done     <= cmd_done_d;
        end
    end

endmodule

// File: tb/tb_nco_sequencer.sv
// Self-checking bench for nco_sequencer: per-cycle queue model of expanded commands,
// directed scenarios with literal expectations, then randomized commands and aborts.
module tb_nco_sequencer;

    localparam int NW = 22;
    localparam int ZW = 12;
    localparam int CW = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op    = 2'b00;
    logic [NW-1:0] cmd_data  = '0;
    logic          abort     = 1'b0;
    logic          cmd_ready;
    logic          ftw_wr_en;
    logic [NW-1:0] ftw_out;
    logic          z_corr_wr_en;
    logic [ZW-1:0] z_corr_out;
    logic          phase_wr_en;
    logic          z_corr_mode;
    logic          cmd_done;
    logic          busy;

    nco_sequencer #(.N(NW), .Z_CORR_WIDTH(ZW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .abort        (abort),
        .ftw_wr_en    (ftw_wr_en),
        .ftw_out      (ftw_out),
        .z_corr_wr_en (z_corr_wr_en),
        .z_corr_out   (z_corr_out),
        .phase_wr_en  (phase_wr_en),
        .z_corr_mode  (z_corr_mode),
        .cmd_done     (cmd_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: each accepted command becomes a list of expected output cycles.
    typedef struct {
        bit            ftw_we;
        logic [NW-1:0] ftw;
        bit            zc_we;
        logic [ZW-1:0] zc;
        bit            ph;
        bit            mode;
        bit            done;
        bit            abort_to_clear;
        bit            abort_completes;
    } step_t;

    step_t         pend[$];
    step_t         cur;
    bit            cur_active = 1'b0;
    logic [NW-1:0] m_ftw      = '0;
    logic [ZW-1:0] m_zc       = '0;

    function automatic step_t blank();
        step_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic step_t clear_step(input bit done);
        step_t s;
        s = blank();
        s.zc_we           = 1'b1;
        s.zc              = '0;
        s.done            = done;
        s.abort_completes = 1'b1;
        return s;
    endfunction

    function automatic void expand(input logic [1:0] op, input logic [NW-1:0] d);
        step_t s;
        int    n;
        case (op)
            2'b00: begin
                s = blank(); s.ftw_we = 1'b1; s.ftw = d; s.done = 1'b1;
                pend.push_back(s);
            end
            2'b01: begin
                s = blank(); s.zc_we = 1'b1; s.zc = d[ZW-1:0]; s.abort_to_clear = 1'b1;
                pend.push_back(s);
                s = blank(); s.ph = 1'b1; s.mode = 1'b1; s.abort_to_clear = 1'b1;
                pend.push_back(s);
                pend.push_back(clear_step(1'b1));
            end
            default: begin
                n = int'(d[CW-1:0]);
                if (n == 0) begin
                    s = blank(); s.done = 1'b1;
                    pend.push_back(s);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        s = blank();
                        s.ph   = (op == 2'b10);
                        s.done = (i == n - 1);
                        pend.push_back(s);
                    end
                end
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            cur        = blank();
            cur_active = 1'b0;
            m_ftw      = '0;
            m_zc       = '0;
        end else begin
            bit rdy;
            rdy = !abort && (!cur_active || pend.size() == 0);
            if (cur_active && abort && !cur.abort_completes) begin
                pend.delete();
                if (cur.abort_to_clear) pend.push_back(clear_step(1'b0));
            end else if (cmd_valid && rdy) begin
                expand(cmd_op, cmd_data);
            end
            if (pend.size() > 0) begin
                cur        = pend.pop_front();
                cur_active = 1'b1;
                if (cur.ftw_we) m_ftw = cur.ftw;
                if (cur.zc_we)  m_zc  = cur.zc;
            end else begin
                cur        = blank();
                cur_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("ftw_wr_en",    ftw_wr_en,    cur.ftw_we);
        check("ftw_out",      ftw_out,      m_ftw);
        check("z_corr_wr_en", z_corr_wr_en, cur.zc_we);
        check("z_corr_out",   z_corr_out,   m_zc);
        check("phase_wr_en",  phase_wr_en,  cur.ph);
        check("z_corr_mode",  z_corr_mode,  cur.mode);
        check("cmd_done",     cmd_done,     cur.done);
        check("busy",         busy,         cur_active);
        check("cmd_ready",    cmd_ready,    !abort && (!cur_active || pend.size() == 0));
    end

    // Small NCO stand-in fed by the DUT outputs, used to confirm the net VZ effect.
    logic [NW-1:0] nco_phase = '0;
    logic [NW-1:0] nco_ftw   = '0;
    logic [ZW-1:0] nco_zc    = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nco_phase <= '0;
            nco_ftw   <= '0;
            nco_zc    <= '0;
        end else begin
            if (phase_wr_en) nco_phase <= nco_phase + (z_corr_mode ? NW'(nco_zc) : nco_ftw);
            if (z_corr_wr_en) nco_zc <= z_corr_out;
            if (ftw_wr_en) nco_ftw <= ftw_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [NW-1:0] d);
        bit ok;
        ok        = 1'b0;
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        check("accept", ok, 1);
    endtask

    initial begin
        logic [NW-1:0] ph0;
        logic [NW-1:0] delta;
        int            cnt;
        int            dn;
        bit            acc;
        bit            ph [1:12];
        bit            rd [1:12];

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ftw_out", ftw_out, 0);
        step();

        // SET_FTW: one strobe cycle with done in the same cycle.
        issue(2'b00, 22'h040000);
        @(negedge clk);
        check("ftw_strobe", ftw_wr_en, 1);
        check("ftw_value", ftw_out, 32'h040000);
        check("ftw_done", cmd_done, 1);
        step();
        @(negedge clk);
        check("ftw_single", ftw_wr_en, 0);
        check("ftw_idle", busy, 0);
        step();

        // VZ: load, apply, clear; the NCO phase moves by exactly z_corr.
        ph0 = nco_phase;
        issue(2'b01, 22'h000123);
        @(negedge clk);
        check("vz_load_en", z_corr_wr_en, 1);
        check("vz_load_val", z_corr_out, 32'h123);
        step();
        @(negedge clk);
        check("vz_apply", {phase_wr_en, z_corr_mode, z_corr_wr_en}, 32'b110);
        step();
        @(negedge clk);
        check("vz_clear", {z_corr_wr_en, cmd_done}, 32'b11);
        check("vz_clear_val", z_corr_out, 0);
        step();
        @(negedge clk);
        check("vz_idle", busy, 0);
        step();
        delta = nco_phase - ph0;
        check("vz_phase_delta", delta, 32'h123);
        check("vz_zc_left", nco_zc, 0);

        // RUN 5 then RUN 3 back to back.
        issue(2'b10, 22'd5);
        cmd_op    = 2'b10;
        cmd_data  = 22'd3;
        cmd_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            ph[i] = phase_wr_en;
            rd[i] = cmd_ready;
            acc   = cmd_valid && cmd_ready;
            step();
            if (acc) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 8; i++) cnt += int'(ph[i]);
        check("run_b2b_count", cnt, 8);
        check("run_b2b_end", ph[9], 0);
        check("run_rdy_c4", rd[4], 0);
        check("run_rdy_c5", rd[5], 1);
        check("run_rdy_c8", rd[8], 1);

        // RUN 0 and WAIT 0.
        issue(2'b10, 22'd0);
        @(negedge clk);
        check("run0_en", {ftw_wr_en, z_corr_wr_en, phase_wr_en}, 0);
        check("run0_done", {cmd_done, busy}, 32'b11);
        step();
        @(negedge clk);
        check("run0_len", busy, 0);
        step();
        issue(2'b11, 22'd0);
        @(negedge clk);
        check("wait0_en", {ftw_wr_en, z_corr_wr_en, phase_wr_en}, 0);
        check("wait0_done", {cmd_done, busy}, 32'b11);
        step();
        @(negedge clk);
        check("wait0_len", busy, 0);
        step();

        // WAIT 2 with junk above the count field.
        issue(2'b11, 22'h3F0002);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(busy);
            step();
        end
        check("wait2_len", cnt, 2);

        // Abort in VZ_APPLY.
        issue(2'b01, 22'h0000AB);
        @(negedge clk);
        step();
        abort = 1'b1;
        @(negedge clk);
        check("vzab_ready", cmd_ready, 0);
        check("vzab_apply", phase_wr_en, 1);
        step();
        abort = 1'b0;
        @(negedge clk);
        check("vzab_clear", {z_corr_wr_en, cmd_done}, 32'b10);
        check("vzab_val", z_corr_out, 0);
        step();
        @(negedge clk);
        check("vzab_idle", busy, 0);
        step();

        // Abort at cycle 2 of RUN 10.
        issue(2'b10, 22'd10);
        cnt = 0;
        dn  = 0;
        for (int i = 1; i <= 12; i++) begin
            abort = (i == 2);
            @(negedge clk);
            cnt += int'(phase_wr_en);
            dn  += int'(cmd_done);
            step();
        end
        abort = 1'b0;
        check("runab_count", cnt, 2);
        check("runab_done", dn, 0);

        // Full-scale count runs exactly 2^CW-1 cycles.
        issue(2'b10, 22'h00FFFF);
        cnt = 0;
        dn  = 0;
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            cnt += int'(phase_wr_en);
            dn  += int'(cmd_done);
            step();
        end
        check("run_max_count", cnt, 65535);
        check("run_max_done", dn, 1);

        // Asynchronous reset mid-RUN, then accept on the first edge after release.
        issue(2'b10, 22'd20);
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_en", {ftw_wr_en, z_corr_wr_en, phase_wr_en, z_corr_mode, cmd_done}, 0);
        check("arst_ftw", ftw_out, 0);
        check("arst_zc", z_corr_out, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", cmd_ready, 1);
        step();
        cmd_op    = 2'b00;
        cmd_data  = 22'h000ABC;
        cmd_valid = 1'b1;
        #2 rst_n = 1'b1;
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("arst_first_cmd", ftw_wr_en, 1);
        check("arst_first_val", ftw_out, 32'hABC);
        step();

        // Randomized commands and aborts, checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            step();
            if (acc || !cmd_valid) begin
                cmd_valid = ($urandom_range(0, 3) != 0);
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_data  = NW'($urandom);
                if (cmd_op[1]) cmd_data[CW-1:0] = CW'($urandom_range(0, 6));
            end
            abort = ($urandom_range(0, 11) == 0);
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_sequencer.md
# nco_sequencer

Command-driven controller that sits directly upstream of the phase-accumulator NCO and generates its `ftw_wr_en`/`ftw`, `z_corr_wr_en`/`z_corr`, `phase_wr_en` and `z_corr_mode` controls. It accepts a stream of opcodes (set frequency, virtual-Z, run, wait) over a valid/ready handshake and expands each one into a cycle-exact control sequence, so that pulse timing and phase coherence are enforced in hardware. It also guarantees that no residual `z_corr` remains loaded in the NCO while it is free-running.

## Interface
- `N`, 22, FTW width; equals the NCO accumulator width.
- `Z_CORR_WIDTH`, 12, z-correction word width.
- `CNT_WIDTH`, 16, RUN/WAIT cycle-count width.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op`  in  2  opcode: 00 SET_FTW, 01 VZ, 10 RUN, 11 WAIT.
- `cmd_data`  in  N  payload: FTW; z_corr in `[Z_CORR_WIDTH-1:0]`; or count in `[CNT_WIDTH-1:0]`.
- `abort`  in  1  synchronous abort of the current command.
- `ftw_wr_en`  out  1  drives NCO `ftw_wr_en`.
- `ftw_out`  out  N  drives NCO `ftw_in`.
- `z_corr_wr_en`  out  1  drives NCO `z_corr_wr_en`.
- `z_corr_out`  out  Z_CORR_WIDTH  drives NCO `z_corr_in`.
- `phase_wr_en`  out  1  drives NCO `phase_wr_en`.
- `z_corr_mode`  out  1  drives NCO `z_corr_mode`.
- `cmd_done`  out  1  one-cycle pulse in the last active cycle of each command.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, FTW, VZ_LOAD, VZ_APPLY, VZ_CLEAR, RUN, WAIT.
- SET_FTW:
  - FTW for 1 cycle.
  - `ftw_wr_en=1`, `ftw_out=cmd_data`.
- VZ (3 cycles):
  - VZ_LOAD: `z_corr_wr_en=1`, `z_corr_out=data`.
  - VZ_APPLY: `phase_wr_en=1`, `z_corr_mode=1`.
  - VZ_CLEAR: `z_corr_wr_en=1`, `z_corr_out=0`.
  - Net NCO effect: phase += z_corr once, with z_corr left at 0.
- RUN n:
  - `phase_wr_en=1`, `z_corr_mode=0` for exactly n cycles.
  - n=0: 1 cycle with all enables low.
- WAIT n:
  - All enables low for max(n,1) cycles.
  - NCO phase is held.
- Down-counter is loaded with n at accept; the state ends in the cycle the counter equals 1 (or immediately if n=0).
- `cmd_ready` is 1 in IDLE and in the last cycle of any command, and 0 when `abort=1`. Consecutive commands therefore run with zero gap, so back-to-back RUNs give continuous `phase_wr_en`.
- No accept → IDLE after the last cycle.
- Abort:
  - From RUN, WAIT or FTW: IDLE next cycle, enables low.
  - From VZ_LOAD or VZ_APPLY: go to VZ_CLEAR (clear is mandatory), then IDLE.
  - In VZ_CLEAR: completes normally.
  - `cmd_done` is not pulsed for aborted commands.
- `z_corr_mode` is 1 only in VZ_APPLY.

## Timing
- All outputs except `cmd_ready` and `busy` are registered.
  - A command accepted at edge k drives its first control cycle in k→k+1.
  - The NCO sees the effect at edge k+1.
- `cmd_ready` and `busy` are combinational from state, counter and `abort`.
- Reset (`rst_n=0`, asynchronous):
  - State IDLE, counter 0.
  - All registered outputs 0; `ftw_out=0`, `z_corr_out=0`.
  - `cmd_ready=1`, `busy=0`.
- Reset mid-VZ leaves NCO z_corr loaded. The NCO is reset by the same reset and therefore clears it; this is required at top level.
- `cmd_valid` with `cmd_ready=0` is ignored. The requester must hold the command stable until it is accepted.
- Counter width rule: a count of `2^CNT_WIDTH-1` must run exactly that many cycles, with no wrap.

## Structure
- Package `nco_seq_pkg`:
  - Opcode enum (OP_SET_FTW, OP_VZ, OP_RUN, OP_WAIT).
  - State enum.
  - Default widths N, Z_CORR_WIDTH, CNT_WIDTH.
- Single module with no sub-module; the down-counter and FSM are inline.
- Output registers and next-state logic are in separate blocks.

## Test plan
- Reset, then SET_FTW 0x040000 → `ftw_wr_en` high for exactly 1 cycle with `ftw_out=0x040000`; `cmd_done` in the same cycle.
- VZ 0x123 → z_corr_wr_en(0x123), phase_wr_en+mode, z_corr_wr_en(0) on 3 consecutive cycles; NCO model phase advances by 0x123 only.
- RUN 5, then RUN 3 back-to-back → `phase_wr_en` high for 8 contiguous cycles; `cmd_ready` high in cycles 5 and 8.
- RUN 0 and WAIT 0 → each 1 cycle, all enables low, `cmd_done` pulsed.
- `abort` in VZ_APPLY → VZ_CLEAR next cycle (z_corr_out=0), then IDLE; no `cmd_done`. Also `abort` at cycle 2 of RUN 10 → exactly 2 phase_wr_en cycles.
- Assert `rst_n=0` asynchronously mid-RUN → all outputs 0 immediately, `busy=0`; a new command is accepted on the first edge after release.
